sram_wb_slave: RTL
==================

Name: sram_wb_slave

Overview:
- Wishbone classic slave that answers the data-memory bus master, turning each single-beat Wishbone cycle into one asynchronous-SRAM read or write.
- Sits between the system Wishbone bus and one 32-bit external SRAM bank.
- Generates the SRAM strobes (chip enable, output enable, write enable, byte enables) with programmable wait states.
- Returns one registered ack per accepted cycle.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; must equal SRAM_DATA_WIDTH.
- SRAM_ADDR_WIDTH, 20, SRAM word-address width.
- SRAM_DATA_WIDTH, 32, SRAM data width.
- READ_WAIT, 1, extra cycles the SRAM stays enabled before read data is sampled (0..15).
- WRITE_WAIT, 1, we_n low-pulse length in cycles, minus 1 (0..15).
- BASE_ADDR, 32'h8000_0000, bank base address; used only with SRAM_ADDR_CHECK_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  ADDR_WIDTH  byte address
- wb_dat_i  in  DATA_WIDTH  write data
- wb_sel_i  in  DATA_WIDTH/8  byte lanes
- wb_dat_o  out  DATA_WIDTH  read data, registered
- wb_ack_o  out  1  one-cycle ack, registered
- wb_err_o  out  1  error, registered (always 0 unless SRAM_ADDR_CHECK_EN)
- sram_addr_o  out  SRAM_ADDR_WIDTH  word address
- sram_data_o  out  SRAM_DATA_WIDTH  write data to pad
- sram_data_i  in  SRAM_DATA_WIDTH  read data from pad
- sram_data_oe_o  out  1  1 = drive pad
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low strobes
- sram_be_n_o  out  SRAM_DATA_WIDTH/8  active-low byte enables

Behaviour:

Reset values (applied asynchronously; an in-flight access is abandoned immediately):
- wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
- ce_n=1, oe_n=1, we_n=1, be_n=all 1.
- sram_addr_o=0, sram_data_o=0, data_oe=0.
- State returns to IDLE.

States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A 4-bit wait counter is used in RD and WR_PULSE.

- IDLE accepts when wb_cyc_i & wb_stb_i & !wb_ack_o; call that sample cycle 0. On accept it latches:
  - sram_addr_o = wb_adr_i[SRAM_ADDR_WIDTH+1:2] (upper bits ignored, so the bank aliases);
  - be_n = ~wb_sel_i;
  - sram_data_o = wb_dat_i.
- Read path:
  - IDLE -> RD with ce_n=0, oe_n=0, data_oe=0, counter=READ_WAIT.
  - RD decrements the counter. At counter==0 it captures sram_data_i into wb_dat_o unmodified (byte extraction is the master's job), sets ce_n/oe_n=1 and moves to DONE.
  - wb_ack_o is high in cycle READ_WAIT+2.
- Write path:
  - IDLE -> WR_SETUP: ce_n=0, data_oe=1, we_n=1.
  - WR_PULSE: we_n=0 for WRITE_WAIT+1 cycles.
  - WR_HOLD: we_n=1, data and address still driven.
  - DONE: ce_n=1, data_oe=0.
  - wb_ack_o is high in cycle WRITE_WAIT+3.
- wb_sel_i==0: no SRAM strobes; IDLE -> DONE directly, so ack appears in cycle 1. For reads, wb_dat_o is unchanged.
- DONE: wb_ack_o is high exactly one cycle, then the block returns to IDLE. The next request is accepted no earlier than the cycle after ack.
  - ack is loaded as (wb_cyc_i & wb_stb_i) on entry to DONE.
  - If the master dropped cyc mid-access, the SRAM access still completes but no ack is issued.
- Address, be_n and data are stable from ce_n falling until ce_n rising. we_n never falls in the same cycle as ce_n or the address changes.
- Inputs other than cyc/stb are ignored outside IDLE.

Optional Feature:
SRAM_ADDR_CHECK_EN
- Defined:
  - In IDLE, if wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2] != BASE_ADDR[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2], no SRAM access is made.
  - wb_err_o=1 for one cycle in cycle 1, and wb_ack_o stays 0.
  - The block returns to IDLE after that cycle.
- Undefined: wb_err_o is tied 0 and upper address bits alias.

Test Plan:
- Reset with cyc/stb idle -> ack=0, ce_n/oe_n/we_n=1, be_n=4'hF, data_oe=0.
- Word write adr=0x8000_0010, dat=0xDEADBEEF, sel=4'hF, WRITE_WAIT=1:
  - sram_addr=0x4, we_n low in cycles 2-3, data_oe=1 in cycles 1-4 (WR_SETUP through WR_HOLD).
  - ack in cycle 4 only.
- Word read of the same address, READ_WAIT=1, SRAM model returns 0xDEADBEEF -> oe_n low in cycles 1-2, wb_dat_o=0xDEADBEEF with ack in cycle 3.
- Byte write sel=4'b0100, dat=0x00AB_0000 -> be_n=4'b1011 throughout the access; a following read returns 0xDEABBEEF.
- wb_cyc_i dropped in cycle 2 of a write -> the we_n pulse still completes, no ack is issued, and the next request is accepted from IDLE.
- With SRAM_ADDR_CHECK_EN, read adr=0x9000_0000 -> err=1 in cycle 1, ack=0, ce_n stays 1.

Source files
------------

// File: rtl/sram_wb_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_wb_slave                                                   |
// | Purpose  : Wishbone classic slave driving one 32-bit asynchronous SRAM     |
// |            bank with programmable read / write wait states.                |
// | Options  : SRAM_ADDR_CHECK_EN - reject accesses outside BASE_ADDR bank.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sram_wb_slave #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    SRAM_ADDR_WIDTH = 20,
    parameter int                    SRAM_DATA_WIDTH = 32,
    parameter int                    READ_WAIT       = 1,
    parameter int                    WRITE_WAIT      = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h8000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
    input  logic [DATA_WIDTH-1:0]        wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
    output logic [DATA_WIDTH-1:0]        wb_dat_o,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr_o,
    output logic [SRAM_DATA_WIDTH-1:0]   sram_data_o,
    input  logic [SRAM_DATA_WIDTH-1:0]   sram_data_i,
    output logic                         sram_data_oe_o,
    output logic                         sram_ce_n_o,
    output logic                         sram_oe_n_o,
    output logic                         sram_we_n_o,
    output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                         state_q,   state_d;
    logic [3:0]                     wait_q,    wait_d;
    logic                           ack_q,     ack_d;
    logic                           err_q,     err_d;
    logic [DATA_WIDTH-1:0]          rdata_q,   rdata_d;
    logic [SRAM_ADDR_WIDTH-1:0]     addr_q,    addr_d;
    logic [SRAM_DATA_WIDTH-1:0]     wdata_q,   wdata_d;
    logic [SRAM_DATA_WIDTH/8-1:0]   be_n_q,    be_n_d;
    logic                           ce_n_q,    ce_n_d;
    logic                           oe_n_q,    oe_n_d;
    logic                           we_n_q,    we_n_d;
    logic                           data_oe_q, data_oe_d;

    logic                           req;
    assign req = wb_cyc_i & wb_stb_i;

`ifdef SRAM_ADDR_CHECK_EN
    logic bank_miss;
    assign bank_miss = wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2]
                    != BASE_ADDR[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2];
    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[1:0], BASE_ADDR[SRAM_ADDR_WIDTH+1:0]};
`else
    // Upper address bits are ignored so the bank aliases across the map.
    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2], wb_adr_i[1:0], BASE_ADDR};
`endif

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ack_d     = ack_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_n_d    = be_n_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        data_oe_d = data_oe_q;

        case (state_q)
            S_IDLE: begin
                if (req && !ack_q) begin
                    addr_d  = wb_adr_i[SRAM_ADDR_WIDTH+1:2];
                    be_n_d  = ~wb_sel_i;
                    wdata_d = wb_dat_i;
`ifdef SRAM_ADDR_CHECK_EN
                    if (bank_miss) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else
`endif
                    if (wb_sel_i == '0) begin
                        ack_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (wb_we_i) begin
                        ce_n_d    = 1'b0;
                        we_n_d    = 1'b1;
                        data_oe_d = 1'b1;
                        state_d   = S_WR_SETUP;
                    end else begin
                        ce_n_d    = 1'b0;
                        oe_n_d    = 1'b0;
                        data_oe_d = 1'b0;
                        wait_d    = 4'(READ_WAIT);
                        state_d   = S_RD;
                    end
                end
            end
            S_RD: begin
                if (wait_q == 4'd0) begin
                    rdata_d = sram_data_i;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    ack_d   = req;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_WR_SETUP: begin
                we_n_d  = 1'b0;
                wait_d  = 4'(WRITE_WAIT);
                state_d = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                // Ack rides on the hold cycle; strobes release on the way back to idle.
                if (wait_q == 4'd0) begin
                    we_n_d  = 1'b1;
                    ack_d   = req;
                    state_d = S_WR_HOLD;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_WR_HOLD: begin
                ack_d     = 1'b0;
                ce_n_d    = 1'b1;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
            S_DONE: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            wait_q    <= 4'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_n_q    <= '1;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_n_q    <= be_n_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign wb_dat_o       = rdata_q;
    assign wb_ack_o       = ack_q;
    assign wb_err_o       = err_q;
    assign sram_addr_o    = addr_q;
    assign sram_data_o    = wdata_q;
    assign sram_data_oe_o = data_oe_q;
    assign sram_ce_n_o    = ce_n_q;
    assign sram_oe_n_o    = oe_n_q;
    assign sram_we_n_o    = we_n_q;
    assign sram_be_n_o    = be_n_q;

endmodule
`default_nettype wire
